// File: rtl/fp_mult_pipe_if.sv
// Operand/result handshake bundle for fp_mult_pipe.
// The master drives operands and accepts results; the slave is the multiplier.
interface fp_mult_pipe_if #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
);
    localparam int unsigned W = 1 + EXP_W + MAN_W;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] c;
    logic [3:0]   flags;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, c, flags
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, c, flags
    );
endinterface

// File: rtl/fp_mult_pipe.sv
// 3-stage pipelined floating-point multiplier: unpack, multiply, normalise/round.
// Round-to-nearest-even, subnormals flushed to zero, flags {invalid, overflow, underflow, inexact}.
module fp_mult_pipe #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input  logic          clk,
    input  logic          reset_n,
    fp_mult_pipe_if.slave bus
);
    localparam int unsigned W    = 1 + EXP_W + MAN_W;
    localparam int unsigned EW   = EXP_W + 2;
    localparam int unsigned PW   = 2 * MAN_W + 2;
    localparam int unsigned BIAS = (1 << (EXP_W - 1)) - 1;

    localparam logic signed [EW-1:0] E_OVF  = EW'((1 << EXP_W) - 1);
    localparam logic signed [EW-1:0] E_ZERO = '0;
    localparam logic [W-1:0]         QNAN   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    // ---------------- global advance ----------------
    logic en;
    logic out_valid_q;
    logic [W-1:0] c_q;
    logic [3:0]   flags_q;

    assign en            = !out_valid_q || bus.out_ready;
    assign bus.in_ready  = en;
    assign bus.out_valid = out_valid_q;
    assign bus.c         = c_q;
    assign bus.flags     = flags_q;

    // ---------------- S1: unpack / classify ----------------
    logic             sa, sb;
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] fa, fb;
    logic             za, zb, infa, infb, nana, nanb;
    logic [EW-1:0]    e1_n;

    assign {sa, ea, fa} = bus.a;
    assign {sb, eb, fb} = bus.b;

    assign za   = (ea == '0);
    assign zb   = (eb == '0);
    assign infa = (ea == '1) && (fa == '0);
    assign infb = (eb == '1) && (fb == '0);
    assign nana = (ea == '1) && (fa != '0);
    assign nanb = (eb == '1) && (fb != '0);
    assign e1_n = {2'b00, ea} + {2'b00, eb} - EW'(BIAS);

    logic             s1_valid, s1_sign, s1_inv, s1_inf, s1_zero;
    logic [EW-1:0]    s1_e;
    logic [MAN_W:0]   s1_ma, s1_mb;

    // ---------------- S2: multiply ----------------
    logic             s2_valid, s2_sign, s2_inv, s2_inf, s2_zero;
    logic [EW-1:0]    s2_e;
    logic [PW-1:0]    s2_p;

    // ---------------- S3: normalise / round / select ----------------
    logic [PW-2:0]    norm;
    logic [MAN_W-1:0] man;
    logic             g, st, inc;
    logic [MAN_W:0]   man_r;
    logic [EW-1:0]    e3;
    logic             ovf, unf;
    logic [W-1:0]     c_n;
    logic [3:0]       f_n;

    always_comb begin
        // Pre-shift so the leading one always sits just above norm's MSB.
        norm  = s2_p[PW-1] ? s2_p[PW-2:0] : {s2_p[PW-3:0], 1'b0};
        man   = norm[PW-2 -: MAN_W];
        g     = norm[PW-2-MAN_W];
        st    = |norm[PW-3-MAN_W:0];
        inc   = g && (st || man[0]);
        man_r = {1'b0, man} + (MAN_W+1)'(inc);
        // A rounding carry leaves man_r[MAN_W-1:0] all zero, so only e needs bumping.
        e3    = s2_e + EW'(s2_p[PW-1]) + EW'(man_r[MAN_W]);
        ovf   = $signed(e3) >= E_OVF;
        unf   = $signed(e3) <= E_ZERO;

        c_n = {s2_sign, e3[EXP_W-1:0], man_r[MAN_W-1:0]};
        f_n = {3'b000, g | st};
        if (s2_inv) begin
            c_n = QNAN;
            f_n = 4'b1000;
        end else if (s2_inf) begin
            c_n = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            f_n = 4'b0000;
        end else if (s2_zero) begin
            c_n = {s2_sign, {(W-1){1'b0}}};
            f_n = 4'b0000;
        end else if (ovf) begin
            c_n = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            f_n = 4'b0101;
        end else if (unf) begin
            c_n = {s2_sign, {(W-1){1'b0}}};
            f_n = 4'b0011;
        end
    end

    // ---------------- pipeline registers ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid    <= 1'b0;
            s1_sign     <= 1'b0;
            s1_inv      <= 1'b0;
            s1_inf      <= 1'b0;
            s1_zero     <= 1'b0;
            s1_e        <= '0;
            s1_ma       <= '0;
            s1_mb       <= '0;
            s2_valid    <= 1'b0;
            s2_sign     <= 1'b0;
            s2_inv      <= 1'b0;
            s2_inf      <= 1'b0;
            s2_zero     <= 1'b0;
            s2_e        <= '0;
            s2_p        <= '0;
            out_valid_q <= 1'b0;
            c_q         <= '0;
            flags_q     <= '0;
        end else if (en) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_sign <= sa ^ sb;
                s1_inv  <= nana || nanb || (infa && zb) || (infb && za);
                s1_inf  <= infa || infb;
                s1_zero <= za || zb;
                s1_e    <= e1_n;
                s1_ma   <= {1'b1, fa};
                s1_mb   <= {1'b1, fb};
            end

            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_sign <= s1_sign;
                s2_inv  <= s1_inv;
                s2_inf  <= s1_inf;
                s2_zero <= s1_zero;
                s2_e    <= s1_e;
                s2_p    <= s1_ma * s1_mb;
            end

            out_valid_q <= s2_valid;
            if (s2_valid) begin
                c_q     <= c_n;
                flags_q <= f_n;
            end
        end
    end
endmodule
